// File: rtl/eb_ser.sv
// Width-reducing serializer: one wide input word becomes RATIO
// narrow output beats, least-significant slice first.
module eb_ser #(
  parameter int I_0_WIDTH = 8,
  parameter int RATIO     = 4,
  parameter int T_0_WIDTH = I_0_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [T_0_WIDTH-1:0] t_0_data,
  input  logic                 t_0_valid,
  output logic                 t_0_ready,
  output logic [I_0_WIDTH-1:0] i_0_data,
  output logic                 i_0_valid,
  input  logic                 i_0_ready
);

  localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  if (RATIO < 1 || T_0_WIDTH != I_0_WIDTH * RATIO) begin : g_bad
    $error("eb_ser: T_0_WIDTH must equal I_0_WIDTH*RATIO");
  end

  logic                 full_q, full_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [T_0_WIDTH-1:0] sh_q, sh_d;
  logic                 last, in_hs, out_hs;

  assign last      = (cnt_q == LAST);
  // Ready during the last beat lets a new word load with no bubble.
  assign t_0_ready = reset_n & (!full_q | (i_0_ready & last));
  assign i_0_valid = reset_n & full_q;
  assign i_0_data  = sh_q[I_0_WIDTH-1:0];
  assign in_hs     = t_0_valid & t_0_ready;
  assign out_hs    = i_0_valid & i_0_ready;

  always_comb begin
    full_d = full_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    if (in_hs) begin
      full_d = 1'b1;
      cnt_d  = '0;
      sh_d   = t_0_data;
    end else if (out_hs) begin
      if (last) begin
        full_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        sh_d  = sh_q >> I_0_WIDTH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
    end else begin
      full_q <= full_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
    end
  end

endmodule

// File: tb/tb_eb_ser.sv
// Bench for eb_ser: directed vector table, random run against a
// beat-queue model, and a RATIO=1 streaming check.
module tb_eb_ser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] td = '0;
  logic        tv = 1'b0;
  logic        tr;
  logic [7:0]  id;
  logic        iv;
  logic        ir = 1'b0;

  logic [7:0]  td1 = '0;
  logic        tv1 = 1'b0;
  logic        tr1;
  logic [7:0]  id1;
  logic        iv1;
  logic        ir1 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  eb_ser #(.I_0_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .t_0_data(td), .t_0_valid(tv), .t_0_ready(tr),
    .i_0_data(id), .i_0_valid(iv), .i_0_ready(ir)
  );

  eb_ser #(.I_0_WIDTH(8), .RATIO(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .t_0_data(td1), .t_0_valid(tv1), .t_0_ready(tr1),
    .i_0_data(id1), .i_0_valid(iv1), .i_0_ready(ir1)
  );

  typedef struct {
    logic        rst;
    logic        tv;
    logic [31:0] td;
    logic        ir;
    logic        etr;
    logic        eiv;
    logic [7:0]  eid;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, input logic v,
                     input logic [31:0] d, input logic r,
                     input logic etr, input logic eiv,
                     input logic [7:0] eid);
    vec_t e;
    e.rst = rst; e.tv = v; e.td = d; e.ir = r;
    e.etr = etr; e.eiv = eiv; e.eid = eid;
    vq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] p[$];
  logic [7:0] rx[$];

  initial begin
    // reset row, then single word
    add(0, 1, 32'h44332211, 1, 0, 0, 8'h00);
    add(1, 1, 32'h44332211, 1, 1, 0, 8'h00);
    add(1, 0, 32'h0, 1, 0, 1, 8'h11);
    add(1, 0, 32'h0, 1, 0, 1, 8'h22);
    add(1, 0, 32'h0, 1, 0, 1, 8'h33);
    add(1, 0, 32'h0, 1, 1, 1, 8'h44);
    add(1, 0, 32'h0, 1, 1, 0, 8'h00);
    // back-to-back words
    add(1, 1, 32'h44332211, 1, 1, 0, 8'h00);
    add(1, 1, 32'h88776655, 1, 0, 1, 8'h11);
    add(1, 1, 32'h88776655, 1, 0, 1, 8'h22);
    add(1, 1, 32'h88776655, 1, 0, 1, 8'h33);
    add(1, 1, 32'h88776655, 1, 1, 1, 8'h44);
    add(1, 0, 32'h0, 1, 0, 1, 8'h55);
    add(1, 0, 32'h0, 1, 0, 1, 8'h66);
    add(1, 0, 32'h0, 1, 0, 1, 8'h77);
    add(1, 0, 32'h0, 1, 1, 1, 8'h88);
    add(1, 0, 32'h0, 1, 1, 0, 8'h00);
    // backpressure on 0x22, ignored t_0_valid while busy
    add(1, 1, 32'h44332211, 1, 1, 0, 8'h00);
    add(1, 1, 32'h99999999, 1, 0, 1, 8'h11);
    add(1, 1, 32'h99999999, 0, 0, 1, 8'h22);
    add(1, 1, 32'h99999999, 0, 0, 1, 8'h22);
    add(1, 0, 32'h0, 0, 0, 1, 8'h22);
    add(1, 0, 32'h0, 1, 0, 1, 8'h22);
    add(1, 0, 32'h0, 1, 0, 1, 8'h33);
    add(1, 0, 32'h0, 0, 0, 1, 8'h44);
    add(1, 0, 32'h0, 1, 1, 1, 8'h44);
    add(1, 0, 32'h0, 1, 1, 0, 8'h00);
    // reset mid-word
    add(1, 1, 32'h44332211, 1, 1, 0, 8'h00);
    add(1, 0, 32'h0, 1, 0, 1, 8'h11);
    add(1, 0, 32'h0, 1, 0, 1, 8'h22);
    add(0, 1, 32'hDDCCBBAA, 1, 0, 0, 8'h00);
    add(1, 1, 32'hDDCCBBAA, 1, 1, 0, 8'h00);
    add(1, 0, 32'h0, 1, 0, 1, 8'hAA);
    add(1, 0, 32'h0, 1, 0, 1, 8'hBB);
    add(1, 0, 32'h0, 1, 0, 1, 8'hCC);
    add(1, 0, 32'h0, 1, 1, 1, 8'hDD);
    add(1, 0, 32'h0, 1, 1, 0, 8'h00);

    for (int i = 0; i < vq.size(); i++) begin
      reset_n = vq[i].rst;
      tv = vq[i].tv;
      td = vq[i].td;
      ir = vq[i].ir;
      @(negedge clk);
      chk($sformatf("vec%0d_tready", i), tr, vq[i].etr);
      chk($sformatf("vec%0d_ivalid", i), iv, vq[i].eiv);
      if (vq[i].eiv)
        chk($sformatf("vec%0d_idata", i), id, vq[i].eid);
      next_cycle();
    end

    // idle after reset
    reset_n = 1'b0; tv = 1'b0; ir = 1'b1;
    next_cycle();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ir = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_ivalid", iv, 1'b0);
      chk("idle_tready", tr, 1'b1);
      next_cycle();
    end

    // random run against a queue of pending output beats
    q.delete();
    for (int i = 0; i < 600; i++) begin
      logic etr, eiv;
      reset_n = ($urandom_range(0, 59) != 0);
      tv = ($urandom_range(0, 2) != 0);
      td = $urandom;
      ir = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!reset_n) begin
        chk("rnd_rst_tready", tr, 1'b0);
        chk("rnd_rst_ivalid", iv, 1'b0);
        q.delete();
      end else begin
        etr = (q.size() == 0) || (q.size() == 1 && ir);
        eiv = (q.size() != 0);
        chk("rnd_tready", tr, etr);
        chk("rnd_ivalid", iv, eiv);
        if (eiv) chk("rnd_idata", id, q[0]);
        if (eiv && ir) void'(q.pop_front());
        if (tv && etr)
          for (int k = 0; k < 4; k++)
            q.push_back(td[8*k +: 8]);
      end
      next_cycle();
    end

    // RATIO=1 stream 0x01..0x10
    tv = 1'b0; ir = 1'b0;
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    begin
      int s;
      s = 0;
      p.delete();
      rx.delete();
      for (int c = 0; c < 200 && rx.size() < 16; c++) begin
        logic etr1, eiv1;
        tv1 = (s < 16);
        td1 = 8'(s + 1);
        ir1 = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        etr1 = (p.size() == 0) || ir1;
        eiv1 = (p.size() != 0);
        chk("r1_tready", tr1, etr1);
        chk("r1_ivalid", iv1, eiv1);
        if (eiv1) chk("r1_idata", id1, p[0]);
        if (iv1 && ir1) rx.push_back(id1);
        if (eiv1 && ir1) void'(p.pop_front());
        if (tv1 && etr1) begin
          p.push_back(td1);
          s++;
        end
        next_cycle();
      end
      tv1 = 1'b0;
      chk("r1_count", rx.size(), 16);
      for (int k = 0; k < rx.size(); k++)
        chk($sformatf("r1_order%0d", k), rx[k], 8'(k + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eb_ser.md
EB_SER -- requirements
Module: eb_ser

Interface
REQ-001 Parameter I_0_WIDTH, default 8: width of one output beat in bits.
REQ-002 Parameter RATIO, default 4: beats per input word; RATIO >= 1.
REQ-003 Parameter T_0_WIDTH, default I_0_WIDTH*RATIO: input word width; any other value SHALL be rejected at elaboration.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 Port t_0_data, input, T_0_WIDTH: wide input word.
REQ-007 Port t_0_valid, input, 1: input word valid.
REQ-008 Port t_0_ready, output, 1: block accepts input word this cycle.
REQ-009 Port i_0_data, output, I_0_WIDTH: current output beat.
REQ-010 Port i_0_valid, output, 1: output beat valid.
REQ-011 Port i_0_ready, input, 1: downstream accepts beat this cycle.

Function
REQ-012 State SHALL be: full flag (1 bit), beat counter cnt (max(1,clog2(RATIO)) bits), shift register shreg (T_0_WIDTH bits).
REQ-013 States: EMPTY (full=0) and BUSY (full=1, cnt = beat index 0..RATIO-1).
REQ-014 i_0_valid SHALL equal full; i_0_data SHALL equal shreg[I_0_WIDTH-1:0].
REQ-015 Input handshake: t_0_valid & t_0_ready; output beat handshake: i_0_valid & i_0_ready; last = (cnt == RATIO-1).
REQ-016 t_0_ready SHALL equal !full | (i_0_ready & last), combinational from i_0_ready; no other combinational input-to-output path.
REQ-017 Input handshake: shreg <= t_0_data, cnt <= 0, full <= 1; first beat valid next cycle (latency 1).
REQ-018 Non-last beat handshake without input handshake: shreg shifts right by I_0_WIDTH, cnt increments.
REQ-019 Last beat handshake without input handshake: full <= 0, cnt <= 0 (BUSY -> EMPTY).
REQ-020 Last beat handshake with simultaneous input handshake: new word loaded, full stays 1, no bubble.
REQ-021 Beat order: least-significant slice first, t_0_data[I_0_WIDTH-1:0] through t_0_data[T_0_WIDTH-1:T_0_WIDTH-I_0_WIDTH].
REQ-022 With i_0_valid high and i_0_ready low, i_0_data, cnt and full SHALL hold; i_0_valid SHALL not drop without a handshake.
REQ-023 Throughput: with i_0_ready held high and t_0_valid held high, one beat every cycle, one word every RATIO cycles.
REQ-024 RATIO=1: last always true; block SHALL behave as a one-entry full-throughput pipeline register.
REQ-025 t_0_valid while BUSY and not on last-beat handshake SHALL be ignored (t_0_ready low); upstream holds word.

Reset
REQ-026 While reset_n is low at a rising edge: full <= 0, cnt <= 0, shreg <= 0.
REQ-027 While reset_n is low, t_0_ready and i_0_valid SHALL both be 0, regardless of state.
REQ-028 Reset mid-word SHALL discard remaining beats; first cycle after reset release: i_0_valid=0, t_0_ready=1.

Verification (I_0_WIDTH=8, RATIO=4 unless stated)
REQ-029 Single word: t_0_data=0x44332211 accepted cycle 0, i_0_ready=1 -> beats 0x11,0x22,0x33,0x44 on cycles 1-4, i_0_valid=0 on cycle 5.
REQ-030 Back-to-back: words 0x44332211, 0x88776655 with t_0_valid and i_0_ready held 1 -> 8 consecutive beats 0x11..0x88, no gap; t_0_ready high only in EMPTY and on last-beat cycles.
REQ-031 Backpressure: i_0_ready=0 for 3 cycles while 0x22 presented -> i_0_data=0x22, i_0_valid=1 held 3 cycles; then 0x33,0x44 follow; t_0_ready=0 throughout.
REQ-032 Reset mid-word: reset_n low for 1 cycle after beat 0x22 -> no further beats of that word; next word 0xDDCCBBAA outputs 0xAA first.
REQ-033 Idle: t_0_valid=0 for 20 cycles after reset -> i_0_valid=0, t_0_ready=1 every cycle.
REQ-034 RATIO=1, I_0_WIDTH=8: stream 0x01..0x10 with random i_0_ready -> output sequence identical to input, one word per cycle when i_0_ready=1.
